multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16: max cycles a memory request may wait for mem_ready before fault (legal range 1..255).
REQ-002 SHALL have parameter SUB_ALU_OP, default 4'b0111: alu_op encoding for SUB/compare.
REQ-003 SHALL have one clock and asynchronous active-high reset, ports as follows:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-high reset
op  in  7  opcode from instruction register
func3  in  3  funct3 from instruction register
func7  in  7  funct7 from instruction register
branch_taken  in  1  branch unit compare result, valid in EXEC
mem_ready  in  1  memory completes current read/write this cycle
ir_write  out  1  latch fetched instruction
pc_write  out  1  update PC this cycle
mem_read  out  1  memory read request
mem_write  out  1  memory write request
reg_write  out  1  register file write
alu_source  out  1  0=rs2, 1=immediate
register_source  out  2  00=memory, 01=ALU, 10=PC+4
imm_source  out  3  000=I, 001=S, 011=B, 100=J
alu_op  out  4  0000 ADD, 0001 SLL, 0010 SRL, 0011 SRA, 0100 AND, 0101 OR, 0110 XOR, SUB_ALU_OP SUB, 1000 branch
pc_source  out  3  000=PC+4, 001=branch target, 101=JAL target, 110=JALR target
jalr_override  out  1  clear bit 0 of JALR target
state  out  3  current FSM state
fault  out  1  sticky illegal-instruction/timeout flag

Function
REQ-004 SHALL implement states FETCH=000, DECODE=001, EXEC=010, MEM=011, WB=100, FAULT=111; other codes SHALL transition to FAULT.
REQ-005 FETCH: mem_read=1; mem_ready=1 -> ir_write=1 same cycle, next DECODE; else stay and increment wait counter.
REQ-006 Wait counter SHALL clear on every state change; reaching MEM_TIMEOUT with mem_ready=0 (in FETCH or MEM) -> next FAULT; mem_ready on the final allowed cycle SHALL win over timeout.
REQ-007 DECODE: opcodes 0000011, 0100011, 0110011, 0010011, 1100011, 1101111, 1100111 -> EXEC; any other opcode, or R-type/shift-immediate with illegal func7 -> FAULT.
REQ-008 EXEC SHALL drive imm_source, alu_source, alu_op per opcode/func3/func7; ADD vs SUB SHALL be distinguished by func7[5] (R-type only); SRAI/SRLI by func7[5].
REQ-009 EXEC transitions: load/store -> MEM; R/I-type -> WB; JAL/JALR -> WB; branch -> FETCH.
REQ-010 Branch in EXEC: alu_op=1000, pc_write=1, pc_source=001 if branch_taken else 000; func3 010/011/110/111 SHALL be treated as illegal -> FAULT, no pc_write.
REQ-011 MEM load: mem_read=1 until mem_ready, then WB; MEM store: mem_write=1 until mem_ready, then pc_write=1, pc_source=000, next FETCH.
REQ-012 WB: reg_write=1 and pc_write=1 for exactly one cycle, next FETCH; register_source 00 load, 01 R/I, 10 JAL/JALR; pc_source 101 JAL, 110 JALR with jalr_override=1, else 000.
REQ-013 Outputs SHALL be Moore/registered-state combinational decode; strobes (ir_write, pc_write, reg_write, mem_read, mem_write) SHALL be 0 in any state/condition not listed.
REQ-014 mem_read and mem_write SHALL never be asserted together.
REQ-015 FAULT: fault=1, all strobes 0, state held until reset.
REQ-016 Zero-wait latency: branch 3 cycles, R/I/JAL/JALR/store 4, load 5.

Reset
REQ-017 rst=1 SHALL immediately force state=FETCH, counter=0, fault=0, all outputs 0 except those FETCH decodes; mem_read SHALL be 0 while rst=1.
REQ-018 rst asserted mid-MEM SHALL abort the access with no reg_write/pc_write.

Verification
REQ-019 ADD x3,x1,x2 (op 0110011, func7 0) with mem_ready=1 -> states 000,001,010,100; WB reg_write=1, register_source=01, alu_op=0000.
REQ-020 SUB (func7 0100000) -> EXEC alu_op=SUB_ALU_OP; LW with mem_ready delayed 3 cycles -> MEM held 4 cycles, WB register_source=00.
REQ-021 BEQ with branch_taken=1 -> EXEC pc_write=1, pc_source=001, next FETCH, total 3 cycles; taken=0 -> pc_source=000.
REQ-022 mem_ready held 0 in FETCH -> FAULT after MEM_TIMEOUT=16 cycles, fault=1 sticky until rst.
REQ-023 op 1111111 -> DECODE to FAULT, no reg_write/pc_write; JALR -> WB pc_source=110, jalr_override=1, register_source=10.
REQ-024 rst pulsed during store MEM -> mem_write drops asynchronously, state=000, no pc_write.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle RISC-V control FSM: fetch/decode/exec/mem/writeback sequencing with
// memory-wait timeout and sticky fault state for illegal instructions.
module multicycle_control #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter logic [3:0]  SUB_ALU_OP  = 4'b0111
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    input  logic       branch_taken,
    input  logic       mem_ready,
    output logic       ir_write,
    output logic       pc_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       alu_source,
    output logic [1:0] register_source,
    output logic [2:0] imm_source,
    output logic [3:0] alu_op,
    output logic [2:0] pc_source,
    output logic       jalr_override,
    output logic [2:0] state,
    output logic       fault
);

    typedef enum logic [2:0] {
        StFetch  = 3'b000,
        StDecode = 3'b001,
        StExec   = 3'b010,
        StMem    = 3'b011,
        StWb     = 3'b100,
        StFault  = 3'b111
    } state_e;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpI      = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;

    localparam logic [6:0] F7Zero = 7'b0000000;
    localparam logic [6:0] F7Alt  = 7'b0100000;

    // Counter value seen on the last allowed wait cycle.
    localparam logic [7:0] TimeoutLast = 8'(MEM_TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       legal_op;
    logic       legal_f7;
    logic       legal_branch;
    logic [3:0] alu_func;

    always_comb begin
        legal_op = 1'b0;
        legal_f7 = 1'b1;
        case (op)
            OpLoad, OpStore, OpBranch, OpJal, OpJalr: legal_op = 1'b1;
            OpR: begin
                legal_op = 1'b1;
                legal_f7 = (func7 == F7Zero) ||
                           ((func7 == F7Alt) && ((func3 == 3'b000) || (func3 == 3'b101)));
            end
            OpI: begin
                legal_op = 1'b1;
                if (func3 == 3'b001) begin
                    legal_f7 = (func7 == F7Zero);
                end else if (func3 == 3'b101) begin
                    legal_f7 = (func7 == F7Zero) || (func7 == F7Alt);
                end
            end
            default: legal_op = 1'b0;
        endcase
    end

    assign legal_branch = (func3 == 3'b000) || (func3 == 3'b001) ||
                          (func3 == 3'b100) || (func3 == 3'b101);

    // func7[5] selects SUB only for register-register ops; immediates have no SUBI.
    always_comb begin
        alu_func = 4'b0000;
        case (func3)
            3'b000:         alu_func = ((op == OpR) && func7[5]) ? SUB_ALU_OP : 4'b0000;
            3'b001:         alu_func = 4'b0001;
            3'b010, 3'b011: alu_func = SUB_ALU_OP;
            3'b100:         alu_func = 4'b0110;
            3'b101:         alu_func = func7[5] ? 4'b0011 : 4'b0010;
            3'b110:         alu_func = 4'b0101;
            3'b111:         alu_func = 4'b0100;
            default:        alu_func = 4'b0000;
        endcase
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        ir_write        = 1'b0;
        pc_write        = 1'b0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        reg_write       = 1'b0;
        alu_source      = 1'b0;
        register_source = 2'b00;
        imm_source      = 3'b000;
        alu_op          = 4'b0000;
        pc_source       = 3'b000;
        jalr_override   = 1'b0;
        fault           = 1'b0;

        case (state_q)
            StFetch: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    state_d  = StDecode;
                end else if (cnt_q == TimeoutLast) begin
                    state_d = StFault;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StDecode: begin
                state_d = (legal_op && legal_f7) ? StExec : StFault;
            end
            StExec: begin
                case (op)
                    OpLoad: begin
                        alu_source = 1'b1;
                        state_d    = StMem;
                    end
                    OpStore: begin
                        alu_source = 1'b1;
                        imm_source = 3'b001;
                        state_d    = StMem;
                    end
                    OpR: begin
                        alu_op  = alu_func;
                        state_d = StWb;
                    end
                    OpI: begin
                        alu_source = 1'b1;
                        alu_op     = alu_func;
                        state_d    = StWb;
                    end
                    OpBranch: begin
                        imm_source = 3'b011;
                        alu_op     = 4'b1000;
                        if (legal_branch) begin
                            pc_write  = 1'b1;
                            pc_source = branch_taken ? 3'b001 : 3'b000;
                            state_d   = StFetch;
                        end else begin
                            state_d = StFault;
                        end
                    end
                    OpJal: begin
                        alu_source = 1'b1;
                        imm_source = 3'b100;
                        state_d    = StWb;
                    end
                    OpJalr: begin
                        alu_source = 1'b1;
                        state_d    = StWb;
                    end
                    default: state_d = StFault;
                endcase
            end
            StMem: begin
                if (op == OpStore) begin
                    mem_write = 1'b1;
                end else begin
                    mem_read = 1'b1;
                end
                if (mem_ready) begin
                    if (op == OpStore) begin
                        pc_write = 1'b1;
                        state_d  = StFetch;
                    end else begin
                        state_d = StWb;
                    end
                end else if (cnt_q == TimeoutLast) begin
                    state_d = StFault;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StWb: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                state_d   = StFetch;
                case (op)
                    OpLoad: register_source = 2'b00;
                    OpJal: begin
                        register_source = 2'b10;
                        pc_source       = 3'b101;
                    end
                    OpJalr: begin
                        register_source = 2'b10;
                        pc_source       = 3'b110;
                        jalr_override   = 1'b1;
                    end
                    default: register_source = 2'b01;
                endcase
            end
            StFault: begin
                fault = 1'b1;
            end
            default: state_d = StFault;
        endcase

        if (state_d != state_q) begin
            cnt_d = 8'd0;
        end

        // Strobes must drop asynchronously, before the state register settles.
        if (rst) begin
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StFetch;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class through the FSM
// and checks strobes, muxes, timeout and reset behaviour against hand-derived values.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] op = 7'b0;
    logic [2:0] func3 = 3'b0;
    logic [6:0] func7 = 7'b0;
    logic       branch_taken = 1'b0;
    logic       mem_ready = 1'b0;
    logic       ir_write, pc_write, mem_read, mem_write, reg_write, alu_source;
    logic [1:0] register_source;
    logic [2:0] imm_source, pc_source, state;
    logic [3:0] alu_op;
    logic       jalr_override, fault;

    int n_pass = 0;
    int n_total = 0;

    multicycle_control dut (
        .clk             (clk),
        .rst             (rst),
        .op              (op),
        .func3           (func3),
        .func7           (func7),
        .branch_taken    (branch_taken),
        .mem_ready       (mem_ready),
        .ir_write        (ir_write),
        .pc_write        (pc_write),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .reg_write       (reg_write),
        .alu_source      (alu_source),
        .register_source (register_source),
        .imm_source      (imm_source),
        .alu_op          (alu_op),
        .pc_source       (pc_source),
        .jalr_override   (jalr_override),
        .state           (state),
        .fault           (fault)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_ready = 1'b0;
        branch_taken = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7);
        op = o;
        func3 = f3;
        func7 = f7;
    endtask

    // From FETCH, return with the DUT sitting in EXEC.
    task automatic to_exec();
        mem_ready = 1'b1;
        cyc();
        mem_ready = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mem_ready = 1'b1;
        #1;
        n_total++;
        if (state !== 3'b000 || mem_read !== 1'b0 || ir_write !== 1'b0 || fault !== 1'b0)
            $display("FAIL reset_hold: state=%b mem_read=%b ir_write=%b fault=%b want 000 0 0 0",
                     state, mem_read, ir_write, fault);
        else n_pass++;
        mem_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_total++;
        if (state !== 3'b000 || mem_read !== 1'b1 || pc_write !== 1'b0 || reg_write !== 1'b0)
            $display("FAIL reset_release: state=%b mem_read=%b pc_write=%b reg_write=%b want 000 1 0 0",
                     state, mem_read, pc_write, reg_write);
        else n_pass++;
    endtask

    task automatic test_add();
        set_instr(7'b0110011, 3'b000, 7'b0000000);
        mem_ready = 1'b1;
        #1;
        n_total++;
        if (state !== 3'b000 || ir_write !== 1'b1 || mem_read !== 1'b1)
            $display("FAIL add_fetch: state=%b ir_write=%b mem_read=%b want 000 1 1",
                     state, ir_write, mem_read);
        else n_pass++;
        cyc();
        mem_ready = 1'b0;
        #1;
        n_total++;
        if (state !== 3'b001 || ir_write !== 1'b0 || mem_read !== 1'b0)
            $display("FAIL add_decode: state=%b ir_write=%b mem_read=%b want 001 0 0",
                     state, ir_write, mem_read);
        else n_pass++;
        cyc();
        n_total++;
        if (state !== 3'b010 || alu_op !== 4'b0000 || alu_source !== 1'b0 || reg_write !== 1'b0)
            $display("FAIL add_exec: state=%b alu_op=%b alu_source=%b reg_write=%b want 010 0000 0 0",
                     state, alu_op, alu_source, reg_write);
        else n_pass++;
        cyc();
        n_total++;
        if (state !== 3'b100 || reg_write !== 1'b1 || pc_write !== 1'b1 ||
            register_source !== 2'b01 || pc_source !== 3'b000)
            $display("FAIL add_wb: state=%b reg_write=%b pc_write=%b rsrc=%b pc_source=%b want 100 1 1 01 000",
                     state, reg_write, pc_write, register_source, pc_source);
        else n_pass++;
        cyc();
        n_total++;
        if (state !== 3'b000 || reg_write !== 1'b0)
            $display("FAIL add_done: state=%b reg_write=%b want 000 0", state, reg_write);
        else n_pass++;
    endtask

    task automatic test_sub_and_shifts();
        set_instr(7'b0110011, 3'b000, 7'b0100000);
        to_exec();
        n_total++;
        if (state !== 3'b010 || alu_op !== 4'b0111)
            $display("FAIL sub_exec: state=%b alu_op=%b want 010 0111", state, alu_op);
        else n_pass++;
        cyc();
        cyc();
        set_instr(7'b0010011, 3'b101, 7'b0100000);
        to_exec();
        n_total++;
        if (alu_op !== 4'b0011 || alu_source !== 1'b1)
            $display("FAIL srai_exec: alu_op=%b alu_source=%b want 0011 1", alu_op, alu_source);
        else n_pass++;
        cyc();
        cyc();
        set_instr(7'b0010011, 3'b101, 7'b0000000);
        to_exec();
        n_total++;
        if (alu_op !== 4'b0010)
            $display("FAIL srli_exec: alu_op=%b want 0010", alu_op);
        else n_pass++;
        cyc();
        cyc();
        // func7[5] must not turn ADDI into SUB.
        set_instr(7'b0010011, 3'b000, 7'b0100000);
        to_exec();
        n_total++;
        if (alu_op !== 4'b0000)
            $display("FAIL addi_exec: alu_op=%b want 0000", alu_op);
        else n_pass++;
        cyc();
        cyc();
    endtask

    task automatic test_load_wait();
        set_instr(7'b0000011, 3'b010, 7'b0000000);
        to_exec();
        n_total++;
        if (alu_source !== 1'b1 || imm_source !== 3'b000 || alu_op !== 4'b0000)
            $display("FAIL lw_exec: alu_source=%b imm_source=%b alu_op=%b want 1 000 0000",
                     alu_source, imm_source, alu_op);
        else n_pass++;
        cyc();
        for (int i = 0; i < 3; i++) begin
            #1;
            n_total++;
            if (state !== 3'b011 || mem_read !== 1'b1 || mem_write !== 1'b0 || reg_write !== 1'b0)
                $display("FAIL lw_mem_wait%0d: state=%b mem_read=%b mem_write=%b want 011 1 0",
                         i, state, mem_read, mem_write);
            else n_pass++;
            cyc();
        end
        mem_ready = 1'b1;
        #1;
        n_total++;
        if (state !== 3'b011 || mem_read !== 1'b1)
            $display("FAIL lw_mem_ready: state=%b mem_read=%b want 011 1", state, mem_read);
        else n_pass++;
        cyc();
        mem_ready = 1'b0;
        #1;
        n_total++;
        if (state !== 3'b100 || register_source !== 2'b00 || reg_write !== 1'b1 || mem_read !== 1'b0)
            $display("FAIL lw_wb: state=%b rsrc=%b reg_write=%b mem_read=%b want 100 00 1 0",
                     state, register_source, reg_write, mem_read);
        else n_pass++;
        cyc();
    endtask

    task automatic test_branch();
        set_instr(7'b1100011, 3'b000, 7'b0000000);
        to_exec();
        branch_taken = 1'b1;
        #1;
        n_total++;
        if (pc_write !== 1'b1 || pc_source !== 3'b001 || alu_op !== 4'b1000 || imm_source !== 3'b011)
            $display("FAIL beq_taken: pc_write=%b pc_source=%b alu_op=%b imm=%b want 1 001 1000 011",
                     pc_write, pc_source, alu_op, imm_source);
        else n_pass++;
        cyc();
        branch_taken = 1'b0;
        n_total++;
        if (state !== 3'b000)
            $display("FAIL beq_next: state=%b want 000", state);
        else n_pass++;
        to_exec();
        n_total++;
        if (pc_write !== 1'b1 || pc_source !== 3'b000)
            $display("FAIL beq_not_taken: pc_write=%b pc_source=%b want 1 000", pc_write, pc_source);
        else n_pass++;
        cyc();
        set_instr(7'b1100011, 3'b110, 7'b0000000);
        to_exec();
        branch_taken = 1'b1;
        #1;
        n_total++;
        if (pc_write !== 1'b0)
            $display("FAIL bltu_no_pc: pc_write=%b want 0", pc_write);
        else n_pass++;
        cyc();
        branch_taken = 1'b0;
        n_total++;
        if (state !== 3'b111 || fault !== 1'b1)
            $display("FAIL bltu_fault: state=%b fault=%b want 111 1", state, fault);
        else n_pass++;
        do_reset();
    endtask

    task automatic test_timeout();
        mem_ready = 1'b0;
        repeat (15) cyc();
        n_total++;
        if (state !== 3'b000 || fault !== 1'b0)
            $display("FAIL timeout_early: state=%b fault=%b want 000 0", state, fault);
        else n_pass++;
        cyc();
        n_total++;
        if (state !== 3'b111 || fault !== 1'b1 || mem_read !== 1'b0)
            $display("FAIL timeout_fault: state=%b fault=%b mem_read=%b want 111 1 0",
                     state, fault, mem_read);
        else n_pass++;
        mem_ready = 1'b1;
        repeat (3) cyc();
        n_total++;
        if (state !== 3'b111 || fault !== 1'b1 || ir_write !== 1'b0 || pc_write !== 1'b0)
            $display("FAIL fault_sticky: state=%b fault=%b ir_write=%b pc_write=%b want 111 1 0 0",
                     state, fault, ir_write, pc_write);
        else n_pass++;
        do_reset();
        #1;
        n_total++;
        if (state !== 3'b000 || fault !== 1'b0)
            $display("FAIL fault_cleared: state=%b fault=%b want 000 0", state, fault);
        else n_pass++;
        set_instr(7'b0110011, 3'b000, 7'b0000000);
        repeat (15) cyc();
        mem_ready = 1'b1;
        #1;
        n_total++;
        if (ir_write !== 1'b1)
            $display("FAIL last_cycle_ready: ir_write=%b want 1", ir_write);
        else n_pass++;
        cyc();
        mem_ready = 1'b0;
        n_total++;
        if (state !== 3'b001)
            $display("FAIL last_cycle_decode: state=%b want 001", state);
        else n_pass++;
        do_reset();
    endtask

    task automatic test_illegal();
        set_instr(7'b1111111, 3'b000, 7'b0000000);
        mem_ready = 1'b1;
        cyc();
        mem_ready = 1'b0;
        #1;
        n_total++;
        if (state !== 3'b001 || reg_write !== 1'b0 || pc_write !== 1'b0)
            $display("FAIL illegal_decode: state=%b reg_write=%b pc_write=%b want 001 0 0",
                     state, reg_write, pc_write);
        else n_pass++;
        cyc();
        n_total++;
        if (state !== 3'b111 || fault !== 1'b1 || pc_write !== 1'b0 || reg_write !== 1'b0)
            $display("FAIL illegal_fault: state=%b fault=%b pc_write=%b reg_write=%b want 111 1 0 0",
                     state, fault, pc_write, reg_write);
        else n_pass++;
        do_reset();
        set_instr(7'b0110011, 3'b000, 7'b0000001);
        to_exec();
        n_total++;
        if (state !== 3'b111)
            $display("FAIL bad_func7: state=%b want 111", state);
        else n_pass++;
        do_reset();
    endtask

    task automatic test_jumps();
        set_instr(7'b1100111, 3'b000, 7'b0000000);
        to_exec();
        n_total++;
        if (alu_source !== 1'b1 || imm_source !== 3'b000)
            $display("FAIL jalr_exec: alu_source=%b imm_source=%b want 1 000", alu_source, imm_source);
        else n_pass++;
        cyc();
        n_total++;
        if (state !== 3'b100 || pc_source !== 3'b110 || jalr_override !== 1'b1 ||
            register_source !== 2'b10 || reg_write !== 1'b1 || pc_write !== 1'b1)
            $display("FAIL jalr_wb: state=%b pc_source=%b jovr=%b rsrc=%b rw=%b pw=%b want 100 110 1 10 1 1",
                     state, pc_source, jalr_override, register_source, reg_write, pc_write);
        else n_pass++;
        cyc();
        set_instr(7'b1101111, 3'b000, 7'b0000000);
        to_exec();
        n_total++;
        if (imm_source !== 3'b100)
            $display("FAIL jal_exec: imm_source=%b want 100", imm_source);
        else n_pass++;
        cyc();
        n_total++;
        if (pc_source !== 3'b101 || jalr_override !== 1'b0 || register_source !== 2'b10)
            $display("FAIL jal_wb: pc_source=%b jovr=%b rsrc=%b want 101 0 10",
                     pc_source, jalr_override, register_source);
        else n_pass++;
        cyc();
    endtask

    task automatic test_store();
        set_instr(7'b0100011, 3'b010, 7'b0000000);
        to_exec();
        n_total++;
        if (imm_source !== 3'b001 || alu_source !== 1'b1)
            $display("FAIL sw_exec: imm_source=%b alu_source=%b want 001 1", imm_source, alu_source);
        else n_pass++;
        cyc();
        mem_ready = 1'b1;
        #1;
        n_total++;
        if (state !== 3'b011 || mem_write !== 1'b1 || mem_read !== 1'b0 ||
            pc_write !== 1'b1 || pc_source !== 3'b000)
            $display("FAIL sw_mem: state=%b mw=%b mr=%b pw=%b pc_source=%b want 011 1 0 1 000",
                     state, mem_write, mem_read, pc_write, pc_source);
        else n_pass++;
        cyc();
        mem_ready = 1'b0;
        n_total++;
        if (state !== 3'b000)
            $display("FAIL sw_done: state=%b want 000", state);
        else n_pass++;
        to_exec();
        cyc();
        #1;
        n_total++;
        if (state !== 3'b011 || mem_write !== 1'b1)
            $display("FAIL sw_abort_pre: state=%b mem_write=%b want 011 1", state, mem_write);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_total++;
        if (state !== 3'b000 || mem_write !== 1'b0 || mem_read !== 1'b0 || pc_write !== 1'b0)
            $display("FAIL sw_abort: state=%b mw=%b mr=%b pw=%b want 000 0 0 0",
                     state, mem_write, mem_read, pc_write);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_and_shifts();
        test_load_wait();
        test_branch();
        test_timeout();
        test_illegal();
        test_jumps();
        test_store();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
